// File: rtl/pad_pwr_seq.sv
// Pad-ring IO supply sequencer: raises POC, enables supply groups one at a time
// behind their power-good, and releases them highest-first on power-down.
//   state   | meaning
//   OFF     | all released, waiting for req_i
//   POC     | POC pad enabled, settling before group 0
//   UP_WAIT | group idx enabled, waiting for its power-good
//   UP_GAP  | stagger gap before the next group or ON
//   ON      | all groups up and good
//   DOWN    | releasing groups highest-first, then one final gap
//   FAULT   | sequence aborted, held until req_i drops
module pad_pwr_seq #(
    parameter int N_GRP   = 3,
    parameter int POC_CYC = 4,
    parameter int STAGGER = 8,
    parameter int TIMEOUT = 16,
    localparam int GW = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [N_GRP-1:0] pwr_good_i,
    output logic             poc_o,
    output logic [N_GRP-1:0] grp_en_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic [GW-1:0]    fault_grp_o
);
    localparam int CMAX_A = (POC_CYC > STAGGER) ? POC_CYC : STAGGER;
    localparam int CMAX   = (CMAX_A > TIMEOUT) ? CMAX_A : TIMEOUT;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LD_POC = CW'(POC_CYC - 1);
    localparam logic [CW-1:0] LD_STG = CW'(STAGGER - 1);
    localparam logic [CW-1:0] LD_TO  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST   = GW'(N_GRP - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_POC,
        S_UP_WAIT,
        S_UP_GAP,
        S_ON,
        S_DOWN,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      idx_q, idx_d;
    logic [N_GRP-1:0]   grp_en_q, grp_en_d;
    logic [GW-1:0]      fgrp_q, fgrp_d;
    logic               poc_q, ready_q, busy_q, fault_q;
    logic               poc_d, ready_d, busy_d, fault_d;

    logic               pg_cur;
    logic [N_GRP-1:0]   bad;
    logic [GW-1:0]      bad_idx;

    assign pg_cur = pwr_good_i[idx_q];
    assign bad    = ~pwr_good_i & grp_en_q;

    always_comb begin
        bad_idx = '0;
        for (int i = N_GRP - 1; i >= 0; i--) begin
            if (bad[i]) bad_idx = GW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        grp_en_d = grp_en_q;
        fgrp_d   = fgrp_q;
        case (state_q)
            S_OFF: begin
                if (req_i) begin
                    state_d = S_POC;
                    cnt_d   = LD_POC;
                end
            end
            S_POC: begin
                if (!req_i) begin
                    state_d = S_DOWN;
                    cnt_d   = LD_STG;
                end else if (cnt_q == '0) begin
                    state_d  = S_UP_WAIT;
                    idx_d    = '0;
                    grp_en_d = N_GRP'(1);
                    cnt_d    = LD_TO;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_UP_WAIT: begin
                if (!pg_cur && cnt_q == '0) begin
                    state_d  = S_FAULT;
                    fgrp_d   = idx_q;
                    grp_en_d = '0;
                    cnt_d    = '0;
                end else if (!req_i) begin
                    state_d = S_DOWN;
                    cnt_d   = LD_STG;
                end else if (pg_cur) begin
                    state_d = S_UP_GAP;
                    cnt_d   = LD_STG;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_UP_GAP: begin
                if (!req_i) begin
                    state_d = S_DOWN;
                    cnt_d   = LD_STG;
                end else if (cnt_q == '0) begin
                    if (idx_q == LAST) begin
                        state_d = S_ON;
                    end else begin
                        state_d  = S_UP_WAIT;
                        idx_d    = idx_q + GW'(1);
                        grp_en_d = grp_en_q | (N_GRP'(1) << (idx_q + GW'(1)));
                        cnt_d    = LD_TO;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ON: begin
                if (|bad) begin
                    state_d  = S_FAULT;
                    fgrp_d   = bad_idx;
                    grp_en_d = '0;
                    cnt_d    = '0;
                end else if (!req_i) begin
                    state_d = S_DOWN;
                    cnt_d   = LD_STG;
                end
            end
            S_DOWN: begin
                if (cnt_q == '0) begin
                    cnt_d = LD_STG;
                    // enables are always contiguous from bit 0, so a shift drops the highest
                    if (grp_en_q != '0) begin
                        grp_en_d = grp_en_q >> 1;
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FAULT: begin
                if (!req_i) begin
                    state_d = S_OFF;
                    fgrp_d  = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d  = S_OFF;
                cnt_d    = '0;
                idx_d    = '0;
                grp_en_d = '0;
                fgrp_d   = '0;
            end
        endcase
    end

    assign poc_d   = (state_d != S_OFF) && (state_d != S_FAULT);
    assign ready_d = (state_d == S_ON);
    assign busy_d  = (state_d == S_POC) || (state_d == S_UP_WAIT) ||
                     (state_d == S_UP_GAP) || (state_d == S_DOWN);
    assign fault_d = (state_d == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            idx_q    <= '0;
            grp_en_q <= '0;
            fgrp_q   <= '0;
            poc_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            grp_en_q <= grp_en_d;
            fgrp_q   <= fgrp_d;
            poc_q    <= poc_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign poc_o       = poc_q;
    assign grp_en_o    = grp_en_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;
    assign fault_grp_o = fgrp_q;
endmodule

// File: tb/tb_pad_pwr_seq.sv
// Bench for pad_pwr_seq: a timestamp-based reference model predicts every output
// cycle into a queue; a negedge monitor pops and compares against the DUT.
module tb_pad_pwr_seq;
    localparam int N = 3;
    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [2:0] pg  = 3'b000;
    logic       poc, ready, busy, fault;
    logic [2:0] grp_en;
    logic [1:0] fgrp;

    logic req_s = 1'b0;
    logic pg_s  = 1'b1;
    logic poc_s, grp_s, ready_s, busy_s, fault_s, fgrp_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pad_pwr_seq #(.N_GRP(N), .POC_CYC(P), .STAGGER(S), .TIMEOUT(T)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .pwr_good_i(pg),
        .poc_o(poc), .grp_en_o(grp_en), .ready_o(ready), .busy_o(busy),
        .fault_o(fault), .fault_grp_o(fgrp)
    );

    pad_pwr_seq #(.N_GRP(1), .POC_CYC(4), .STAGGER(1), .TIMEOUT(16)) u_small (
        .clk(clk), .rst(rst), .req_i(req_s), .pwr_good_i(pg_s),
        .poc_o(poc_s), .grp_en_o(grp_s), .ready_o(ready_s), .busy_o(busy_s),
        .fault_o(fault_s), .fault_grp_o(fgrp_s)
    );

    typedef struct packed {
        logic       poc;
        logic [2:0] grp;
        logic       ready;
        logic       busy;
        logic       fault;
        logic [1:0] fgrp;
    } obs_t;

    typedef enum int {M_OFF, M_POC, M_RAMP, M_ON, M_DOWN, M_FAULT} mode_t;

    obs_t  exp_q[$];
    mode_t mode = M_OFF;
    int    cyc = 0, t0 = 0, t_en = 0, t_good = -1, t_dn = 0;
    int    n_on = 0, n_dn0 = 0, f_idx = 0;

    // Reference model: phases plus event timestamps; groups on tracked as a count.
    initial forever begin
        obs_t e;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mode = M_OFF; n_on = 0; f_idx = 0; t_good = -1;
        end else begin
            case (mode)
                M_OFF: if (req) begin mode = M_POC; t0 = cyc; end
                M_POC: begin
                    if (!req) begin
                        mode = M_DOWN; t_dn = cyc; n_dn0 = n_on;
                    end else if (cyc == t0 + P) begin
                        mode = M_RAMP; n_on = 1; t_en = cyc; t_good = -1;
                    end
                end
                M_RAMP: begin
                    if (t_good < 0 && !pg[n_on-1] && cyc == t_en + T) begin
                        mode = M_FAULT; f_idx = n_on - 1; n_on = 0;
                    end else if (!req) begin
                        mode = M_DOWN; t_dn = cyc; n_dn0 = n_on;
                    end else if (t_good < 0) begin
                        if (pg[n_on-1]) t_good = cyc;
                    end else if (cyc == t_good + S) begin
                        if (n_on == N) mode = M_ON;
                        else begin n_on++; t_en = cyc; t_good = -1; end
                    end
                end
                M_ON: begin
                    if (pg != 3'b111) begin
                        for (int i = N - 1; i >= 0; i--) if (!pg[i]) f_idx = i;
                        mode = M_FAULT; n_on = 0;
                    end else if (!req) begin
                        mode = M_DOWN; t_dn = cyc; n_dn0 = n_on;
                    end
                end
                M_DOWN: begin
                    int m;
                    m = (cyc - t_dn) / S;
                    n_on = (m >= n_dn0) ? 0 : n_dn0 - m;
                    if (cyc == t_dn + (n_dn0 + 1) * S) mode = M_OFF;
                end
                M_FAULT: if (!req) begin mode = M_OFF; f_idx = 0; end
                default: mode = M_OFF;
            endcase
        end
        e.poc   = (mode == M_POC) || (mode == M_RAMP) || (mode == M_ON) || (mode == M_DOWN);
        e.grp   = 3'((1 << n_on) - 1);
        e.ready = (mode == M_ON);
        e.busy  = (mode == M_POC) || (mode == M_RAMP) || (mode == M_DOWN);
        e.fault = (mode == M_FAULT);
        e.fgrp  = (mode == M_FAULT) ? 2'(f_idx) : 2'b00;
        exp_q.push_back(e);
    end

    initial forever begin
        obs_t a, e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{poc: poc, grp: grp_en, ready: ready, busy: busy, fault: fault, fgrp: fgrp};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outs cyc=%0d actual poc/grp/rdy/busy/flt/fgrp=%b required=%b",
                         cyc, a, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_episode();
        int   hold, low;
        int   dly[3];
        logic fast;
        logic [2:0] v;
        hold = $urandom_range(10, 90);
        low  = $urandom_range(1, 45);
        fast = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) dly[i] = fast ? $urandom_range(0, 3) : $urandom_range(0, 50);
        req = 1'b1;
        for (int c = 0; c < hold; c++) begin
            for (int i = 0; i < 3; i++) v[i] = (c >= dly[i]);
            if ($urandom_range(0, 99) == 0) v[$urandom_range(0, 2)] = 1'b0;
            pg  = v;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;
        req = 1'b0;
        for (int c = 0; c < low; c++) begin
            if ($urandom_range(0, 49) == 0) pg = 3'($urandom);
            step(1);
        end
    endtask

    initial begin
        int n;
        step(3);
        rst = 1'b0;
        step(2);

        // single-group, single-cycle stagger corner
        req_s = 1'b1;
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (ready_s) begin n = i; break; end
        end
        checks++;
        if (n != 7) begin
            failures++;
            $display("FAIL small_ready_latency actual=%0d required=7", n);
        end
        checks++;
        if (grp_s !== 1'b1 || poc_s !== 1'b1 || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL small_on_outputs actual grp=%b poc=%b busy=%b required 1 1 0",
                     grp_s, poc_s, busy_s);
        end
        req_s = 1'b0;
        step(4);

        // clean power-up then full power-down
        pg = 3'b111; req = 1'b1; step(60);
        req = 1'b0; step(40);

        // group 1 never good: timeout, held while req stays high
        pg = 3'b101; req = 1'b1; step(60);
        req = 1'b0; step(5);

        // one-cycle brown-out of group 2 in ON
        pg = 3'b111; req = 1'b1; step(40);
        pg = 3'b011; step(1);
        pg = 3'b111; step(10);
        req = 1'b0; step(5);

        // timeout coinciding with req falling
        pg = 3'b000; req = 1'b1; step(P + T);
        req = 1'b0; step(5);

        // abort in UP_GAP with two groups up, re-request during DOWN
        pg = 3'b111; req = 1'b1; step(17);
        req = 1'b0; step(3);
        req = 1'b1; step(30);
        req = 1'b0; step(40);

        // reset in UP_WAIT
        pg = 3'b000; req = 1'b1; step(8);
        rst = 1'b1; step(1);
        rst = 1'b0; req = 1'b0; step(5);

        for (int ep = 0; ep < 50; ep++) run_episode();

        req = 1'b0; step(45);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pad_pwr_seq.md
# pad_pwr_seq

Parametrised power-up/power-down sequencer for the pad ring's IO supply groups. It steps N_GRP pad-supply groups on one at a time behind the power-on-control (POC) pad, waits for each group's power-good, and staggers the enables to limit inrush. On power-down it releases the groups in reverse order. It sits between the SoC power controller (request side) and the pad-ring enable/POC nets.

## Interface
- N_GRP, 3: number of IO supply groups, ≥1.
- POC_CYC, 4: cycles poc_o is held before group 0 is enabled, ≥1.
- STAGGER, 8: gap cycles between group steps, up and down, ≥1.
- TIMEOUT, 16: maximum cycles to wait for power-good after a group is enabled, ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous and active-high.
- req_i  in  1  level request: 1 = power up, 0 = power down.
- pwr_good_i  in  N_GRP  per-group power-good; synchronous to clk.
- poc_o  out  1  power-on-control enable.
- grp_en_o  out  N_GRP  per-group supply enables.
- ready_o  out  1  all groups up and good.
- busy_o  out  1  sequencing in progress (POC, UP_WAIT, UP_GAP, DOWN).
- fault_o  out  1  sequence aborted.
- fault_grp_o  out  clog2(N_GRP) (min 1)  index of the failing group.

## Operation
- All outputs are registered.
- Reset value of every output is 0. Reset puts the FSM in OFF with idx=0 and cnt=0.
- States: OFF, POC, UP_WAIT, UP_GAP, ON, DOWN, FAULT.
- Priority when events coincide: rst > fault > req_i=0 > normal progress.
- **OFF**
  - All outputs 0.
  - req_i=1 → POC, with cnt=0.
- **POC**
  - poc_o=1.
  - After POC_CYC cycles in POC → UP_WAIT with idx=0. grp_en_o[0] sets on the same edge.
- **UP_WAIT**
  - cnt increments each cycle.
  - pwr_good_i[idx]=1 → UP_GAP, with cnt=0.
  - If TIMEOUT cycles elapse without pwr_good_i[idx] → FAULT, with fault_grp_o=idx.
- **UP_GAP**
  - Lasts STAGGER cycles.
  - If idx=N_GRP-1 → ON.
  - Otherwise idx+1, grp_en_o[idx+1] sets, → UP_WAIT.
- **ON**
  - ready_o=1.
  - Any enabled group's pwr_good_i=0 → FAULT, with fault_grp_o = lowest such index.
  - req_i=0 → DOWN.
- **req_i=0 during POC, UP_WAIT or UP_GAP** → DOWN. Groups already enabled stay enabled until released.
- **DOWN**
  - ready_o=0 on entry; poc_o stays 1.
  - Every STAGGER cycles, clear the highest set bit of grp_en_o.
  - Once grp_en_o=0 (immediately if already 0 on entry), wait one further STAGGER period → OFF, poc_o=0.
  - req_i is ignored until OFF is reached. If req_i is still 1 in OFF, power-up restarts.
- **FAULT**
  - grp_en_o=0, poc_o=0, ready_o=0, busy_o=0, fault_o=1; fault_grp_o is held.
  - Exits to OFF only after req_i=0 is sampled. fault_o and fault_grp_o clear on that transition.
- pwr_good_i of groups not yet enabled is don't-care.
- pwr_good_i of enabled groups is not checked in UP_WAIT/UP_GAP for indices below idx; it is checked only in ON.

## Timing
Edge k is the first edge sampling req_i=1 in OFF.
- poc_o=1 from k+1.
- grp_en_o[0]=1 from k+1+POC_CYC.
- With pwr_good_i already high:
  - each group costs 1 cycle in UP_WAIT plus STAGGER cycles in UP_GAP;
  - ready_o rises at k+1+POC_CYC+N_GRP·(1+STAGGER).
- Timeout: FAULT entered exactly TIMEOUT cycles after UP_WAIT entry.
- Power-down, with edge j the first edge sampling req_i=0 in ON:
  - DOWN from j+1;
  - bit clears at j+1+m·STAGGER for m=1..N_GRP;
  - OFF with poc_o=0 at j+1+(N_GRP+1)·STAGGER.
- Fault reaction from ON: outputs drop one edge after pwr_good_i=0 is sampled.
- Synchronous reset mid-sequence: all outputs 0 on the next edge, no ordered release.

## Test plan
Defaults for all scenarios: N_GRP=3, POC_CYC=4, STAGGER=8, TIMEOUT=16.
- **Power-up:** pwr_good_i=3'b111, req_i rises (sampled at k) → poc_o at k+1; grp_en_o 001 at k+5, 011 at k+14, 111 at k+23; ready_o at k+32; busy_o high k+1..k+31.
- **Power-down:** from ON, req_i falls (sampled at j) → ready_o=0 at j+1; grp_en_o 011 at j+9, 001 at j+17, 000 at j+25; poc_o=0 and OFF at j+33.
- **Timeout:** pwr_good_i[1] held 0 → FAULT 16 cycles after grp_en_o[1] rises; grp_en_o=000, poc_o=0, fault_o=1, fault_grp_o=1; clears only after req_i=0.
- **Brown-out in ON:** pulse pwr_good_i[2]=0 for 1 cycle → next edge FAULT, fault_grp_o=2; req_i held 1 keeps FAULT.
- **Abort mid-up:** req_i falls while in UP_GAP with grp_en_o=011 → DOWN; 001 after 8 cycles, 000 after 16, OFF after 24; a req_i re-rise during DOWN is ignored until OFF.
- **Reset and corners:** rst asserted mid-UP_WAIT → all outputs 0 next edge. Simultaneous timeout and req_i=0 → FAULT. N_GRP=1, STAGGER=1 → ready_o at k+1+4+2.
